// File: rtl/onehot_decode_tracker_pkg.sv
// Shared op encodings and sizing helper for the one-hot decode tracker.
package onehot_decode_tracker_pkg;

    typedef enum logic [1:0] {
        DEC_OP_PULSE = 2'b00,
        DEC_OP_SET   = 2'b01,
        DEC_OP_CLEAR = 2'b10,
        DEC_OP_QUERY = 2'b11
    } dec_op_e;

    // Width of a counter able to hold 0..n inclusive.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/onehot_decode_tracker_if.sv
// Request/response bundle of the one-hot decode tracker.
// occ_count exists only when ONEHOT_DECODE_POPCNT_EN is defined.
interface onehot_decode_tracker_if
    import onehot_decode_tracker_pkg::*;
#(
    parameter int unsigned IDX_W = 6,
    parameter int unsigned N_OUT = 40
) ();

    logic             in_valid;
    logic [IDX_W-1:0] in_idx;
    dec_op_e          in_op;
    logic             clear_all;
    logic             out_valid;
    logic [N_OUT-1:0] out_onehot;
    logic [N_OUT-1:0] out_bitmap;
    logic             out_err;
    logic             out_hit;
    logic             full;
    logic             empty;
`ifdef ONEHOT_DECODE_POPCNT_EN
    logic [cnt_width(N_OUT)-1:0] occ_count;
`endif

    modport master (
        output in_valid, in_idx, in_op, clear_all,
        input  out_valid, out_onehot, out_bitmap, out_err, out_hit, full, empty
`ifdef ONEHOT_DECODE_POPCNT_EN
        , input occ_count
`endif
    );

    modport slave (
        input  in_valid, in_idx, in_op, clear_all,
        output out_valid, out_onehot, out_bitmap, out_err, out_hit, full, empty
`ifdef ONEHOT_DECODE_POPCNT_EN
        , output occ_count
`endif
    );

endinterface

// File: rtl/onehot_decode_tracker_core.sv
// Combinational index to one-hot decode with an in-range flag.
module onehot_dec_core #(
    parameter int unsigned IDX_W = 6,
    parameter int unsigned N_OUT = 40
) (
    input  logic [IDX_W-1:0] idx,
    output logic [N_OUT-1:0] onehot,
    output logic             in_range
);

    // Extra bit keeps the compare exact when N_OUT == 2**IDX_W.
    assign in_range = ({1'b0, idx} < (IDX_W + 1)'(N_OUT));

    always_comb begin
        onehot = '0;
        for (int i = 0; i < int'(N_OUT); i++) begin
            onehot[i] = (idx == IDX_W'(i));
        end
    end

endmodule

// File: rtl/onehot_decode_tracker.sv
// Registered one-hot decoder with sticky occupancy bitmap and error flagging.
// Optional registered popcount output enabled by ONEHOT_DECODE_POPCNT_EN.
module onehot_decode_tracker
    import onehot_decode_tracker_pkg::*;
#(
    parameter int unsigned IDX_W = 6,
    parameter int unsigned N_OUT = 40
) (
    input logic                    clk,
    input logic                    rst,
    onehot_decode_tracker_if.slave bus
);

    logic [N_OUT-1:0] dec_onehot;
    logic             in_range;

    logic [N_OUT-1:0] bitmap_q, bitmap_d;
    logic [N_OUT-1:0] onehot_q;
    logic             valid_q, err_q, hit_q;
    logic             cur_bit, req_err;

    onehot_dec_core #(
        .IDX_W (IDX_W),
        .N_OUT (N_OUT)
    ) u_core (
        .idx      (bus.in_idx),
        .onehot   (dec_onehot),
        .in_range (in_range)
    );

    // Masking with the decode avoids indexing past N_OUT for bad indices.
    assign cur_bit = |(dec_onehot & bitmap_q);

    always_comb begin
        req_err = !in_range;
        if (bus.in_op == DEC_OP_SET   &&  cur_bit) req_err = 1'b1;
        if (bus.in_op == DEC_OP_CLEAR && !cur_bit) req_err = 1'b1;
    end

    always_comb begin
        bitmap_d = bitmap_q;
        if (bus.clear_all) begin
            bitmap_d = '0;
        end else if (bus.in_valid && !req_err) begin
            if (bus.in_op == DEC_OP_SET)   bitmap_d = bitmap_q | dec_onehot;
            if (bus.in_op == DEC_OP_CLEAR) bitmap_d = bitmap_q & ~dec_onehot;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bitmap_q <= '0;
            onehot_q <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            hit_q    <= 1'b0;
        end else begin
            bitmap_q <= bitmap_d;
            valid_q  <= bus.in_valid;
            onehot_q <= (bus.in_valid && !req_err) ? dec_onehot : '0;
            err_q    <= bus.in_valid && req_err;
            hit_q    <= bus.in_valid && in_range && (bus.in_op == DEC_OP_QUERY) && cur_bit;
        end
    end

    assign bus.out_valid  = valid_q;
    assign bus.out_onehot = onehot_q;
    assign bus.out_err    = err_q;
    assign bus.out_hit    = hit_q;
    assign bus.out_bitmap = bitmap_q;
    assign bus.full       = &bitmap_q;
    assign bus.empty      = ~|bitmap_q;

`ifdef ONEHOT_DECODE_POPCNT_EN
    localparam int unsigned CNT_W = cnt_width(N_OUT);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < int'(N_OUT); i++) begin
            cnt_d = cnt_d + CNT_W'(bitmap_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign bus.occ_count = cnt_q;
`endif

endmodule

// File: tb/tb_onehot_decode_tracker.sv
// Directed bench: N_OUT=40 and N_OUT=64 trackers driven with identical requests.
module tb_onehot_decode_tracker;
    import onehot_decode_tracker_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_total = 0;
    int   n_bad   = 0;

    onehot_decode_tracker_if #(.IDX_W(6), .N_OUT(40)) bus40 ();
    onehot_decode_tracker_if #(.IDX_W(6), .N_OUT(64)) bus64 ();

    onehot_decode_tracker #(.IDX_W(6), .N_OUT(40)) u_dut40 (
        .clk (clk),
        .rst (rst),
        .bus (bus40.slave)
    );

    onehot_decode_tracker #(.IDX_W(6), .N_OUT(64)) u_dut64 (
        .clk (clk),
        .rst (rst),
        .bus (bus64.slave)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Apply one request to both trackers and sample 1ns after the edge.
    task automatic drive(input logic v, input int idx, input dec_op_e op, input logic ca);
        bus40.in_valid  = v;
        bus40.in_idx    = 6'(idx);
        bus40.in_op     = op;
        bus40.clear_all = ca;
        bus64.in_valid  = v;
        bus64.in_idx    = 6'(idx);
        bus64.in_op     = op;
        bus64.clear_all = ca;
        @(posedge clk);
        #1;
    endtask

    localparam logic [63:0] ALL40 = 64'h0000_00FF_FFFF_FFFF;

    initial begin
        drive(1'b0, 0, DEC_OP_PULSE, 1'b0);
        drive(1'b0, 0, DEC_OP_PULSE, 1'b0);
        rst = 1'b0;
        drive(1'b0, 0, DEC_OP_PULSE, 1'b0);
        check_eq("rst_valid",  64'(bus40.out_valid),  64'd0);
        check_eq("rst_bitmap", 64'(bus40.out_bitmap), 64'd0);
        check_eq("rst_onehot", 64'(bus40.out_onehot), 64'd0);
        check_eq("rst_empty",  64'(bus40.empty),      64'd1);
        check_eq("rst_full",   64'(bus40.full),       64'd0);
        check_eq("rst_err",    64'(bus40.out_err),    64'd0);
`ifdef ONEHOT_DECODE_POPCNT_EN
        check_eq("rst_occ",    64'(bus40.occ_count),  64'd0);
`endif

        drive(1'b1, 5, DEC_OP_SET, 1'b0);
        check_eq("set5_valid",  64'(bus40.out_valid),  64'd1);
        check_eq("set5_onehot", 64'(bus40.out_onehot), 64'h20);
        check_eq("set5_bitmap", 64'(bus40.out_bitmap), 64'h20);
        check_eq("set5_err",    64'(bus40.out_err),    64'd0);
        check_eq("set5_empty",  64'(bus40.empty),      64'd0);

        drive(1'b1, 5, DEC_OP_QUERY, 1'b0);
        check_eq("q5_hit",    64'(bus40.out_hit),    64'd1);
        check_eq("q5_err",    64'(bus40.out_err),    64'd0);
        check_eq("q5_onehot", 64'(bus40.out_onehot), 64'h20);

        drive(1'b1, 6, DEC_OP_QUERY, 1'b0);
        check_eq("q6_hit",    64'(bus40.out_hit),    64'd0);
        check_eq("q6_onehot", 64'(bus40.out_onehot), 64'h40);

        drive(1'b1, 5, DEC_OP_SET, 1'b0);
        check_eq("dset_err",    64'(bus40.out_err),    64'd1);
        check_eq("dset_onehot", 64'(bus40.out_onehot), 64'd0);
        check_eq("dset_bitmap", 64'(bus40.out_bitmap), 64'h20);

        drive(1'b1, 7, DEC_OP_CLEAR, 1'b0);
        check_eq("dclr_err",    64'(bus40.out_err),    64'd1);
        check_eq("dclr_bitmap", 64'(bus40.out_bitmap), 64'h20);

        drive(1'b1, 39, DEC_OP_PULSE, 1'b0);
        check_eq("pulse39_onehot", 64'(bus40.out_onehot), 64'h80_0000_0000);
        check_eq("pulse39_err",    64'(bus40.out_err),    64'd0);
        check_eq("pulse39_bitmap", 64'(bus40.out_bitmap), 64'h20);

        drive(1'b1, 45, DEC_OP_SET, 1'b0);
        check_eq("oor_set_err",    64'(bus40.out_err),    64'd1);
        check_eq("oor_set_onehot", 64'(bus40.out_onehot), 64'd0);
        check_eq("oor_set_bitmap", 64'(bus40.out_bitmap), 64'h20);
        check_eq("w64_set45_err",  64'(bus64.out_err),    64'd0);
        check_eq("w64_set45_oh",   64'(bus64.out_onehot), 64'h2000_0000_0000);

        drive(1'b1, 45, DEC_OP_QUERY, 1'b0);
        check_eq("oor_q_err",     64'(bus40.out_err), 64'd1);
        check_eq("oor_q_hit",     64'(bus40.out_hit), 64'd0);
        check_eq("w64_q45_hit",   64'(bus64.out_hit), 64'd1);

        drive(1'b1, 5, DEC_OP_CLEAR, 1'b0);
        check_eq("clr5_onehot", 64'(bus40.out_onehot), 64'h20);
        check_eq("clr5_bitmap", 64'(bus40.out_bitmap), 64'd0);
        check_eq("clr5_empty",  64'(bus40.empty),      64'd1);
        check_eq("w64_clr5_bm", 64'(bus64.out_bitmap), 64'h2000_0000_0000);

        drive(1'b0, 3, DEC_OP_SET, 1'b0);
        check_eq("idle_valid",  64'(bus40.out_valid),  64'd0);
        check_eq("idle_onehot", 64'(bus40.out_onehot), 64'd0);
        check_eq("idle_bitmap", 64'(bus40.out_bitmap), 64'd0);

        for (int i = 0; i < 40; i++) begin
            drive(1'b1, i, DEC_OP_SET, 1'b0);
            check_eq($sformatf("fill%0d_err", i), 64'(bus40.out_err), 64'd0);
        end
        check_eq("fill_full",   64'(bus40.full),       64'd1);
        check_eq("fill_bitmap", 64'(bus40.out_bitmap), ALL40);
        check_eq("w64_full",    64'(bus64.full),       64'd0);
        check_eq("w64_bitmap",  64'(bus64.out_bitmap), ALL40 | 64'h2000_0000_0000);
`ifdef ONEHOT_DECODE_POPCNT_EN
        check_eq("fill_occ",    64'(bus40.occ_count),  64'd40);
        check_eq("w64_occ",     64'(bus64.occ_count),  64'd41);
`endif

        drive(1'b1, 3, DEC_OP_SET, 1'b1);
        check_eq("ca_err",     64'(bus40.out_err),    64'd1);
        check_eq("ca_bitmap",  64'(bus40.out_bitmap), 64'd0);
        check_eq("ca_empty",   64'(bus40.empty),      64'd1);
        check_eq("ca_full",    64'(bus40.full),       64'd0);
        check_eq("w64_ca_err", 64'(bus64.out_err),    64'd1);
`ifdef ONEHOT_DECODE_POPCNT_EN
        check_eq("ca_occ",     64'(bus40.occ_count),  64'd0);
`endif

        // Pre-clear bitmap is empty, so SET is legal but its effect is discarded.
        drive(1'b1, 4, DEC_OP_SET, 1'b1);
        check_eq("ca_set_err",    64'(bus40.out_err),    64'd0);
        check_eq("ca_set_onehot", 64'(bus40.out_onehot), 64'h10);
        check_eq("ca_set_bitmap", 64'(bus40.out_bitmap), 64'd0);

        drive(1'b1, 63, DEC_OP_SET, 1'b0);
        check_eq("set63_err40", 64'(bus40.out_err),    64'd1);
        check_eq("set63_oh64",  64'(bus64.out_onehot), 64'h8000_0000_0000_0000);
        check_eq("set63_bm64",  64'(bus64.out_bitmap), 64'h8000_0000_0000_0000);

        drive(1'b1, 2, DEC_OP_SET, 1'b0);
        check_eq("set2_bitmap", 64'(bus40.out_bitmap), 64'h4);
        rst = 1'b1;
        drive(1'b1, 9, DEC_OP_SET, 1'b0);
        check_eq("mrst_valid",   64'(bus40.out_valid),  64'd0);
        check_eq("mrst_bitmap",  64'(bus40.out_bitmap), 64'd0);
        check_eq("mrst_onehot",  64'(bus40.out_onehot), 64'd0);
        check_eq("w64_mrst_val", 64'(bus64.out_valid),  64'd0);
        check_eq("w64_mrst_bm",  64'(bus64.out_bitmap), 64'd0);
        rst = 1'b0;
        drive(1'b0, 0, DEC_OP_PULSE, 1'b0);
        check_eq("post_rst_valid", 64'(bus40.out_valid),  64'd0);
        check_eq("post_rst_empty", 64'(bus64.empty),      64'd1);
`ifdef ONEHOT_DECODE_POPCNT_EN
        check_eq("post_rst_occ",   64'(bus64.occ_count),  64'd0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
